// File: rtl/qu_common.sv
// Shared back-end types: reservation-station cell layout, slot address type,
// default depth and the physical register tag width.
package qu_common;

  localparam int RS_DEPTH_DEFAULT  = 8;
  localparam int PHY_RF_ADDR_WIDTH = 6;
  localparam int RS_OP_WIDTH       = 16;
  localparam int RS_ADDR_WIDTH     = $clog2(RS_DEPTH_DEFAULT);

  typedef logic [RS_ADDR_WIDTH-1:0]     res_st_addr_t;
  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_tag_t;

  // One renamed micro-op as written by rename and held in a slot.
  typedef struct packed {
    logic [RS_OP_WIDTH-1:0] op;
    phy_tag_t               rd_tag;
    phy_tag_t               rs1_tag;
    logic                   rs1_rdy;
    logic [31:0]            rs1_val;
    phy_tag_t               rs2_tag;
    logic                   rs2_rdy;
    logic [31:0]            rs2_val;
  } res_st_cell_t;

  // Apply a CDB broadcast to a cell: any not-ready operand whose tag matches
  // becomes ready with the broadcast value. Used on the write path so a uop
  // written in the same cycle as its producer's broadcast does not miss it.
  function automatic res_st_cell_t capture_cell(input res_st_cell_t c,
                                                input logic         cdb_valid,
                                                input phy_tag_t     cdb_tag,
                                                input logic [31:0]  cdb_data);
    res_st_cell_t r;
    r = c;
    if (cdb_valid && !c.rs1_rdy && (c.rs1_tag == cdb_tag)) begin
      r.rs1_rdy = 1'b1;
      r.rs1_val = cdb_data;
    end
    if (cdb_valid && !c.rs2_rdy && (c.rs2_tag == cdb_tag)) begin
      r.rs2_rdy = 1'b1;
      r.rs2_val = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_priority_select.sv
// Lowest-index fixed-priority picker. Produces a one-hot grant, its encoded
// index and a found flag. Index is 0 when nothing is requested.
module rs_priority_select #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest requesting index is the last writer.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/res_station.sv
// Reservation station: addressed slots written by rename, CDB snooping for
// operand wakeup, lowest-index selection into a one-deep issue register.
// Optional feature macro: QU_RS_WAKEUP_BYPASS_EN -- when defined, an operand
// matching the current CDB broadcast counts as ready for selection and its
// value is forwarded straight into the issue register.
//
// Issue handshake: issue_valid rises when the issue register holds a uop and
// stays high, with the payload stable, until a rising edge on which
// issue_ready is high; that edge completes the transfer and may load the next
// selected uop in the same cycle.
module res_station
  import qu_common::*;
#(
  parameter  int RS_DEPTH  = RS_DEPTH_DEFAULT,
  parameter  int TAG_WIDTH = PHY_RF_ADDR_WIDTH,
  parameter  int OP_WIDTH  = RS_OP_WIDTH,
  localparam int AW        = $clog2(RS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  res_st_cell_t         wr_data,
  output logic                 wr_err,
  output logic [AW-1:0]        free_addr,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_data,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [OP_WIDTH-1:0]  issue_op,
  output logic [TAG_WIDTH-1:0] issue_rd_tag,
  output logic [31:0]          issue_rs1_val,
  output logic [31:0]          issue_rs2_val
);

  logic [RS_DEPTH-1:0] valid_q;
  res_st_cell_t        cell_q [RS_DEPTH];

  logic [RS_DEPTH-1:0] wake1;
  logic [RS_DEPTH-1:0] wake2;
  logic [RS_DEPTH-1:0] eligible;

  logic [RS_DEPTH-1:0] sel_oh;
  logic [AW-1:0]       sel_idx;
  logic                sel_found;

  logic [RS_DEPTH-1:0] free_oh_unused;
  logic                free_found;

  logic                issue_load;
  logic                issue_take;
  res_st_cell_t        sel_cell;
  logic [31:0]         sel_rs1_val;
  logic [31:0]         sel_rs2_val;

  // Per-slot wakeup match against the broadcast and selection eligibility.
  always_comb begin
    wake1    = '0;
    wake2    = '0;
    eligible = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake1[i] = valid_q[i] && cdb_valid && !cell_q[i].rs1_rdy &&
                 (cell_q[i].rs1_tag == cdb_tag);
      wake2[i] = valid_q[i] && cdb_valid && !cell_q[i].rs2_rdy &&
                 (cell_q[i].rs2_tag == cdb_tag);
`ifdef QU_RS_WAKEUP_BYPASS_EN
      eligible[i] = valid_q[i] && (cell_q[i].rs1_rdy || wake1[i]) &&
                    (cell_q[i].rs2_rdy || wake2[i]);
`else
      eligible[i] = valid_q[i] && cell_q[i].rs1_rdy && cell_q[i].rs2_rdy;
`endif
    end
  end

  rs_priority_select #(.N(RS_DEPTH)) u_issue_sel (
    .req   (eligible),
    .grant (sel_oh),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // free_addr/full look only at registered valid bits, no write forwarding.
  rs_priority_select #(.N(RS_DEPTH)) u_free_sel (
    .req   (~valid_q),
    .grant (free_oh_unused),
    .idx   (free_addr),
    .found (free_found)
  );

  assign full = ~free_found;

  // The issue register accepts a new uop when empty or draining this cycle.
  assign issue_load = !issue_valid || issue_ready;
  assign issue_take = issue_load && sel_found;

  // Payload of the selected slot, with same-cycle CDB forwarding if enabled.
  always_comb begin
    sel_cell    = cell_q[sel_idx];
    sel_rs1_val = sel_cell.rs1_val;
    sel_rs2_val = sel_cell.rs2_val;
`ifdef QU_RS_WAKEUP_BYPASS_EN
    if (wake1[sel_idx]) sel_rs1_val = cdb_data;
    if (wake2[sel_idx]) sel_rs2_val = cdb_data;
`endif
  end

  // Slot state: flush clears, otherwise issue frees, wakeup updates, write loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        cell_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (issue_take && sel_oh[i]) begin
          valid_q[i] <= 1'b0;
        end
        if (wake1[i]) begin
          cell_q[i].rs1_rdy <= 1'b1;
          cell_q[i].rs1_val <= cdb_data;
        end
        if (wake2[i]) begin
          cell_q[i].rs2_rdy <= 1'b1;
          cell_q[i].rs2_val <= cdb_data;
        end
        // Writes only land in empty slots; a write to a busy slot is dropped.
        if (wr_en && (wr_addr == AW'(i)) && !valid_q[i]) begin
          valid_q[i] <= 1'b1;
          cell_q[i]  <= capture_cell(wr_data, cdb_valid, cdb_tag, cdb_data);
        end
      end
    end
  end

  // One-cycle error pulse for a write that hit an occupied slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err <= 1'b0;
    end else if (flush) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && valid_q[wr_addr];
    end
  end

  // One-deep issue register towards the execution unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid   <= 1'b0;
      issue_op      <= '0;
      issue_rd_tag  <= '0;
      issue_rs1_val <= '0;
      issue_rs2_val <= '0;
    end else if (flush) begin
      issue_valid   <= 1'b0;
      issue_op      <= '0;
      issue_rd_tag  <= '0;
      issue_rs1_val <= '0;
      issue_rs2_val <= '0;
    end else if (issue_load) begin
      issue_valid <= sel_found;
      if (sel_found) begin
        issue_op      <= sel_cell.op;
        issue_rd_tag  <= sel_cell.rd_tag;
        issue_rs1_val <= sel_rs1_val;
        issue_rs2_val <= sel_rs2_val;
      end
    end
  end

endmodule

// File: tb/tb_res_station.sv
// Bench for res_station: directed scenarios plus randomized traffic, checked
// against a slot-array reference model through an expected-issue queue.
module tb_res_station;
  import qu_common::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TW    = PHY_RF_ADDR_WIDTH;
  localparam int W     = 16 + TW + 64;
`ifdef QU_RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS   = 1'b1;
  localparam int WAKE_LAT = 1;
`else
  localparam bit BYPASS   = 1'b0;
  localparam int WAKE_LAT = 2;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  res_st_cell_t  wr_data;
  logic          wr_err;
  logic [AW-1:0] free_addr;
  logic          full;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          issue_valid;
  logic          issue_ready;
  logic [15:0]   issue_op;
  logic [TW-1:0] issue_rd_tag;
  logic [31:0]   issue_rs1_val;
  logic [31:0]   issue_rs2_val;

  res_station dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_err        (wr_err),
    .free_addr     (free_addr),
    .full          (full),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_rd_tag  (issue_rd_tag),
    .issue_rs1_val (issue_rs1_val),
    .issue_rs2_val (issue_rs2_val)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_valid [DEPTH];
  res_st_cell_t m_cell  [DEPTH];
  bit           m_iss_valid;
  bit           m_wr_err;

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_cell[i]  = '0;
    end
    m_iss_valid = 1'b0;
    m_wr_err    = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_update();
    bit           w1 [DEPTH];
    bit           w2 [DEPTH];
    int           sel;
    bit           wr_ok;
    bit           err_n;
    res_st_cell_t c;
    logic [31:0]  v1;
    logic [31:0]  v2;
    if (!rst || flush) begin
      model_clear();
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w1[i] = m_valid[i] && cdb_valid && !m_cell[i].rs1_rdy && (m_cell[i].rs1_tag == cdb_tag);
      w2[i] = m_valid[i] && cdb_valid && !m_cell[i].rs2_rdy && (m_cell[i].rs2_tag == cdb_tag);
    end
    sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel < 0 && m_valid[i] &&
          (m_cell[i].rs1_rdy || (BYPASS && w1[i])) &&
          (m_cell[i].rs2_rdy || (BYPASS && w2[i])))
        sel = i;
    end
    err_n = wr_en && m_valid[wr_addr];
    wr_ok = wr_en && !m_valid[wr_addr];
    if (!m_iss_valid || issue_ready) begin
      if (sel >= 0) begin
        v1 = w1[sel] ? cdb_data : m_cell[sel].rs1_val;
        v2 = w2[sel] ? cdb_data : m_cell[sel].rs2_val;
        exp_q.push_back({m_cell[sel].op, m_cell[sel].rd_tag, v1, v2});
        m_valid[sel] = 1'b0;
        m_iss_valid  = 1'b1;
      end else begin
        m_iss_valid = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w1[i]) begin m_cell[i].rs1_rdy = 1'b1; m_cell[i].rs1_val = cdb_data; end
      if (w2[i]) begin m_cell[i].rs2_rdy = 1'b1; m_cell[i].rs2_val = cdb_data; end
    end
    if (wr_ok) begin
      c = wr_data;
      if (cdb_valid && !c.rs1_rdy && c.rs1_tag == cdb_tag) begin c.rs1_rdy = 1'b1; c.rs1_val = cdb_data; end
      if (cdb_valid && !c.rs2_rdy && c.rs2_tag == cdb_tag) begin c.rs2_rdy = 1'b1; c.rs2_val = cdb_data; end
      m_cell[wr_addr]  = c;
      m_valid[wr_addr] = 1'b1;
    end
    m_wr_err = err_n;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("issue_valid", issue_valid, m_iss_valid);
    chk("full", full, m_full());
    chk("free_addr", free_addr, m_free());
    chk("wr_err", wr_err, m_wr_err);
    if (issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL issue_unexpected: got op %0h expected no issue at %0t", issue_op, $time);
      end else begin
        e = exp_q.pop_front();
        chk("issue_payload", {issue_op, issue_rd_tag, issue_rs1_val, issue_rs2_val}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic res_st_cell_t mk(input logic [15:0] op, input int rd,
                                      input int t1, input bit r1, input logic [31:0] v1,
                                      input int t2, input bit r2, input logic [31:0] v2);
    res_st_cell_t c;
    c.op      = op;
    c.rd_tag  = TW'(rd);
    c.rs1_tag = TW'(t1);
    c.rs1_rdy = r1;
    c.rs1_val = v1;
    c.rs2_tag = TW'(t2);
    c.rs2_rdy = r2;
    c.rs2_val = v2;
    return c;
  endfunction

  task automatic do_write(input int addr, input res_st_cell_t c);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = c;
    cycle();
    wr_en   = 1'b0;
  endtask

  // Waits (bounded) for issue_valid; returns cycles counted from the call, 0 on timeout.
  task automatic wait_issue(input int max, output int lat);
    lat = 0;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (issue_valid) begin
        lat = k;
        return;
      end
      cycle();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    model_clear();
    #2 rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("reset_payload", {issue_valid, issue_op, issue_rd_tag, issue_rs1_val, issue_rs2_val}, '0);
    chk("reset_flags", {wr_err, full, free_addr}, '0);
    cycle();
    cycle();
    rst = 1'b1;
    issue_ready = 1'b1;
    cycle();

    // Fully ready uop: issue two cycles after the write.
    do_write(0, mk(16'h0101, 3, 0, 1'b1, 32'd5, 0, 1'b1, 32'd7));
    @(negedge clk);
    chk("t1_not_early", issue_valid, 1'b0);
    cycle();
    @(negedge clk);
    chk("t1_latency", issue_valid, 1'b1);
    chk("t1_vals", {issue_rd_tag, issue_rs1_val, issue_rs2_val}, {TW'(3), 32'd5, 32'd7});
    chk("t1_free", free_addr, 0);
    cycle();

    // rs2 pending on tag 9, broadcast two cycles after the write.
    do_write(1, mk(16'h0202, 4, 0, 1'b1, 32'h1111, 9, 1'b0, 32'h0));
    cycle();
    cdb_valid = 1'b1; cdb_tag = TW'(9); cdb_data = 32'hABCD;
    cycle();
    cdb_valid = 1'b0;
    wait_issue(6, lat);
    chk("t2_wake_latency", lat, WAKE_LAT);
    chk("t2_vals", {issue_rs1_val, issue_rs2_val}, {32'h1111, 32'hABCD});
    cycle();
    cycle();

    // Fill every slot with waiting uops, then a write to busy slot 2.
    for (int i = 0; i < DEPTH; i++)
      do_write(i, mk(16'h0300 + 16'(i), i, 20 + i, 1'b0, 32'h0, 0, 1'b1, 32'hC0 + i));
    @(negedge clk);
    chk("t3_full", full, 1'b1);
    do_write(2, mk(16'h0BAD, 1, 1, 1'b1, 32'h0, 1, 1'b1, 32'h0));
    @(negedge clk);
    chk("t3_wr_err", wr_err, 1'b1);
    cycle();
    @(negedge clk);
    chk("t3_wr_err_pulse", wr_err, 1'b0);
    cdb_valid = 1'b1; cdb_tag = TW'(22); cdb_data = 32'h2222;
    cycle();
    cdb_valid = 1'b0;
    wait_issue(6, lat);
    chk("t3_slot2_kept", {issue_op, issue_rs1_val, issue_rs2_val}, {16'h0302, 32'h2222, 32'hC2});
    cycle();

    // Flush with entries pending: nothing survives.
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_flush", {issue_valid, full}, 2'b00);
    for (int k = 0; k < DEPTH; k++) begin
      cdb_valid = 1'b1; cdb_tag = TW'(20 + k); cdb_data = 32'h5A5A0000 + k;
      cycle();
      @(negedge clk);
      chk("t4_no_issue", issue_valid, 1'b0);
    end
    cdb_valid = 1'b0;
    cycle();

    // Two ready slots with the consumer stalled.
    issue_ready = 1'b0;
    do_write(1, mk(16'h0401, 11, 0, 1'b1, 32'h41, 0, 1'b1, 32'h42));
    do_write(4, mk(16'h0404, 14, 0, 1'b1, 32'h44, 0, 1'b1, 32'h45));
    @(negedge clk);
    chk("t5_first", {issue_valid, issue_op}, {1'b1, 16'h0401});
    for (int k = 0; k < 3; k++) begin
      cycle();
      @(negedge clk);
      chk("t5_hold", {issue_valid, issue_op, issue_rs1_val}, {1'b1, 16'h0401, 32'h41});
    end
    cycle();
    issue_ready = 1'b1;
    @(negedge clk);
    chk("t5_accept1", {issue_valid, issue_op}, {1'b1, 16'h0401});
    cycle();
    @(negedge clk);
    chk("t5_accept2", {issue_valid, issue_op, issue_rd_tag}, {1'b1, 16'h0404, TW'(14)});
    cycle();
    @(negedge clk);
    chk("t5_drained", issue_valid, 1'b0);

    // Write-time capture of a same-cycle broadcast.
    cycle();
    cdb_valid = 1'b1; cdb_tag = TW'(6); cdb_data = 32'h11;
    do_write(0, mk(16'h0505, 5, 6, 1'b0, 32'h0, 0, 1'b1, 32'h22));
    cdb_valid = 1'b0;
    cycle();
    @(negedge clk);
    chk("t6_capture", {issue_valid, issue_rs1_val, issue_rs2_val}, {1'b1, 32'h11, 32'h22});
    cycle();
    cycle();

    // Reset mid-issue.
    issue_ready = 1'b0;
    do_write(0, mk(16'h0601, 1, 0, 1'b1, 32'h1, 0, 1'b1, 32'h2));
    do_write(2, mk(16'h0602, 2, 0, 1'b1, 32'h3, 0, 1'b1, 32'h4));
    do_write(3, mk(16'h0603, 3, 30, 1'b0, 32'h0, 0, 1'b1, 32'h5));
    @(negedge clk);
    chk("t7_pre", issue_valid, 1'b1);
    cycle();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("t7_reset", {issue_valid, full, issue_op, issue_rs1_val}, '0);
    cycle();
    cycle();
    rst = 1'b1;
    issue_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cdb_valid = (k == 1); cdb_tag = TW'(30); cdb_data = 32'h30;
      cycle();
      @(negedge clk);
      chk("t7_no_stale", issue_valid, 1'b0);
    end
    cdb_valid = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'(m_free());
      wr_data = mk(16'($urandom), $urandom_range(0, 63),
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom);
      cdb_valid   = ($urandom_range(0, 99) < 40);
      cdb_tag     = TW'($urandom_range(0, 7));
      cdb_data    = $urandom;
      issue_ready = ($urandom_range(0, 99) < 70);
      flush       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    // Drain: broadcast every tag and accept everything.
    wr_en = 1'b0; flush = 1'b0; issue_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cdb_valid = 1'b1; cdb_tag = TW'(c % 8); cdb_data = 32'hD0000000 + c;
      cycle();
    end
    cdb_valid = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    chk("drain_empty", {exp_q.size(), full, issue_valid}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/res_station.md
# res_station

Reservation station for the Qu back-end, and the receiving end of the rename stage's `res_st_wr_*` write interface. It stores renamed micro-ops in addressed slots and snoops the common data bus (CDB) to wake up pending source operands. It selects one fully-ready entry per cycle and issues it through a registered valid/ready port to a single execution unit. It exports the lowest free slot address and a full flag, which rename uses to steer its writes.

## Interface
- `RS_DEPTH`, 8: number of entries; power of two, at least 2.
- `TAG_WIDTH`, `PHY_RF_ADDR_WIDTH`: physical register tag width.
- `OP_WIDTH`, 16: opaque op/function payload width, carried through unchanged.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous clear of all entries and the issue register.
- `wr_en` in 1: slot write strobe from rename.
- `wr_addr` in `$clog2(RS_DEPTH)`: target slot.
- `wr_data` in `res_st_cell_t`: {op, rd_tag, rs1_tag, rs1_rdy, rs1_val[31:0], rs2_tag, rs2_rdy, rs2_val[31:0]}.
- `wr_err` out 1: one-cycle pulse when a write targets an occupied slot.
- `free_addr` out `$clog2(RS_DEPTH)`: lowest-index invalid slot; 0 when full.
- `full` out 1: all slots valid.
- `cdb_valid` in 1, `cdb_tag` in `TAG_WIDTH`, `cdb_data` in 32: result broadcast.
- `issue_valid` out 1, `issue_ready` in 1: issue handshake.
- `issue_op` out `OP_WIDTH`, `issue_rd_tag` out `TAG_WIDTH`, `issue_rs1_val` out 32, `issue_rs2_val` out 32: issued payload.

## Operation
- Each slot holds a valid bit plus one cell. Reset and flush clear all valid bits and the issue register.
- Write:
  - `wr_en` with an invalid target slot loads the cell and sets valid.
  - A write to a valid slot is dropped and pulses `wr_err` on the next cycle.
- Write-time capture:
  - Applies when `cdb_valid` is high, the operand's `*_rdy` is 0 and `*_tag == cdb_tag` in the same cycle as the write.
  - The operand is stored ready with `cdb_data`. This is never compiled out.
- Wakeup: each cycle, every valid entry with a not-ready operand whose tag equals `cdb_tag` (and `cdb_valid` high) sets that operand ready and latches `cdb_data`. Both operands may wake on the same broadcast.
- Selection:
  - An entry is eligible when it is valid and both operands are ready.
  - Fixed priority picks the lowest index.
- Issue register (one deep):
  - Loads the selected entry when it is empty or when `issue_valid && issue_ready` holds this cycle.
  - The selected slot's valid bit clears on the same edge.
  - Otherwise it holds its contents and `issue_valid` stays high until accepted.
- Flush takes priority over write, wakeup and issue. Reset takes priority over everything.

## Timing
- Reset values: `issue_valid`=0, all `issue_*` payload=0, `wr_err`=0, `full`=0, `free_addr`=0.
- `free_addr` and `full` come from registered valid bits only, with no same-cycle write forwarding.
- Latency from a write of a fully-ready uop in cycle N to `issue_valid` high: cycle N+2.
- Back-to-back ready entries with `issue_ready` held high sustain one issue per cycle.
- Reset asserted mid-operation clears state immediately. No stale issue appears after reset deasserts.

## Configuration
- `QU_RS_WAKEUP_BYPASS_EN` defined:
  - Eligibility also counts an operand as ready if it matches the current-cycle CDB broadcast.
  - The woken value is forwarded straight into the issue register, so wakeup in cycle N gives `issue_valid` in N+1.
- Undefined: eligibility uses stored ready bits only, so wakeup in cycle N gives `issue_valid` in N+2. This shortens the critical path.

## Structure
- `res_st_cell_t` and `res_st_addr_t` live in `qu_common`, with `RS_DEPTH` default and the tag width constant.
- One sub-module, `rs_priority_select`: a parameterised lowest-index one-hot/encoded picker. It is reused for both issue selection and `free_addr`.

## Test plan
- Write slot 0, both operands ready (rs1_val=5, rs2_val=7, rd_tag=3) in cycle N:
  - `issue_valid` in N+2 with vals 5/7 and tag 3.
  - Slot 0 becomes free again (`free_addr`=0).
- Write slot 1 with rs2 pending on tag 9, then CDB tag 9 with data 0xABCD two cycles later:
  - Issues with rs2_val=0xABCD, 1 cycle after the broadcast with the macro defined, 2 without.
- Fill all 8 slots with not-ready entries:
  - `full`=1.
  - An extra write to slot 2 → `wr_err` pulse, slot 2 contents unchanged.
- Slots 1 and 4 both ready with `issue_ready`=0 for 3 cycles:
  - Slot 1's payload holds stable.
  - Then raise `issue_ready` → slot 1 then slot 4 on consecutive cycles.
- Write with rs1 tag 6 not ready, same cycle as CDB tag 6 data 0x11 → entry captures 0x11 and issues.
- Entries pending plus `flush` (and separately `rst` low mid-issue) → `issue_valid`=0 and `full`=0 on the next cycle, no later issues.
